riscv_lsu: RTL and testbench

//  Load/store unit downstream of the instruction decoder. Consumes the decoder's mem_req/mem_we/mem_size
//  and the ALU-computed address; runs a req/gnt/rvalid transaction on the data-memory bus.

---
 rtl/riscv_lsu.sv | 184 ++++++++++++++++++
 tb/tb_riscv_lsu.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between decoder/ALU and the data-memory bus.
// Runs req/gnt/rvalid transactions, stalls the core, formats store/load data.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   lsu_req_i/we_i/size_i        access request from decoder (held while stalled)
//   lsu_addr_i, lsu_data_i       byte address, store data
//   lsu_data_o                   extended load result (valid in DONE)
//   lsu_stall_req_o              hold the pipeline
//   lsu_fault_o                  one-cycle pulse: misaligned, bad size, timeout
//   data_req_o/we_o/be_o         bus request, write enable, byte enables
//   data_addr_o, data_wdata_o    word address, replicated store data
//   data_gnt_i, data_rvalid_i    bus grant, bus response
//   data_rdata_i                 read word
module riscv_lsu #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_fault_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    // Counter only needs to reach RESP_TIMEOUT-1.
    localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t        r_state;
    logic [2:0]    r_size;
    logic [1:0]    r_off;
    logic [CW-1:0] r_cnt;
    logic          r_fault;
    logic [31:0]   r_data;
    logic          r_req;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;

    logic          w_size_ok;
    logic          w_aligned;
    logic          w_legal;
    logic          w_timeout;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shift;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;

    // Request decode: legality, byte enables and store-data replication.
    always_comb begin
        w_size_ok = 1'b0;
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = lsu_data_i;
        case (lsu_size_i)
            3'd0, 3'd4: begin
                w_size_ok = 1'b1;
                w_aligned = 1'b1;
                w_be      = 4'b0001 << lsu_addr_i[1:0];
                w_wdata   = {4{lsu_data_i[7:0]}};
            end
            3'd1, 3'd5: begin
                w_size_ok = 1'b1;
                w_aligned = ~lsu_addr_i[0];
                w_be      = 4'b0011 << {lsu_addr_i[1], 1'b0};
                w_wdata   = {2{lsu_data_i[15:0]}};
            end
            3'd2: begin
                w_size_ok = 1'b1;
                w_aligned = (lsu_addr_i[1:0] == 2'b00);
                w_be      = 4'b1111;
            end
            default: ;
        endcase
    end

    assign w_legal = w_size_ok & w_aligned;

    // Load formatting uses the latched size/offset, not the live inputs.
    always_comb begin
        w_shift = data_rdata_i >> {r_off, 3'b000};
        w_half  = r_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (r_size)
            3'd0:    w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd1:    w_ext = {{16{w_half[15]}}, w_half};
            3'd4:    w_ext = {24'd0, w_shift[7:0]};
            3'd5:    w_ext = {16'd0, w_half};
            default: w_ext = data_rdata_i;
        endcase
    end

    assign w_timeout = (RESP_TIMEOUT != 0) &&
                       (r_cnt == CW'(RESP_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_data  <= 32'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_i) begin
                        if (w_legal) begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_we    <= lsu_we_i;
                            r_be    <= w_be;
                            r_addr  <= {lsu_addr_i[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_size  <= lsu_size_i;
                            r_off   <= lsu_addr_i[1:0];
                            r_cnt   <= '0;
                        end else begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_timeout) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_data  <= 32'd0;
                    end else if (data_gnt_i) begin
                        r_state <= S_RESP;
                        r_req   <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_cnt <= r_cnt + CW'(1);
                    // rvalid is never looked at in REQ, so a same-cycle
                    // gnt+rvalid is not taken as the response.
                    if (w_timeout) begin
                        r_state <= S_DONE;
                        r_fault <= 1'b1;
                        r_data  <= 32'd0;
                    end else if (data_rvalid_i) begin
                        r_state <= S_DONE;
                        if (!r_we) r_data <= w_ext;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_stall_req_o = ((r_state == S_IDLE) && lsu_req_i && w_legal) ||
                             (r_state == S_REQ) || (r_state == S_RESP);
    assign lsu_fault_o     = r_fault;
    assign lsu_data_o      = r_data;
    assign data_req_o      = r_req;
    assign data_we_o       = r_we;
    assign data_be_o       = r_be;
    assign data_addr_o     = r_addr;
    assign data_wdata_o    = r_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized and directed bench for riscv_lsu.
// Reference model computes enables/data/latency from the access rules.
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_fault_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int n_pass = 0;
    int n_total = 0;

    riscv_lsu #(.RESP_TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
        .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i),
        .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
        .lsu_stall_req_o(lsu_stall_req_o), .lsu_fault_o(lsu_fault_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic legal_m(logic [2:0] sz, logic [31:0] a);
        int off;
        off = int'(a % 4);
        case (sz)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (off % 2) == 0;
            3'd2:       return off == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_m(logic [2:0] sz, logic [31:0] a);
        int off;
        off = int'(a % 4);
        case (sz)
            3'd0, 3'd4: return 4'(1 << off);
            3'd1, 3'd5: return (off >= 2) ? 4'hC : 4'h3;
            default:    return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] wd_m(logic [2:0] sz, logic [31:0] d);
        case (sz)
            3'd0, 3'd4: return (d & 32'hFF) * 32'h0101_0101;
            3'd1, 3'd5: return (d & 32'hFFFF) * 32'h0001_0001;
            default:    return d;
        endcase
    endfunction

    function automatic logic [31:0] ld_m(logic [2:0] sz, logic [31:0] a,
                                         logic [31:0] rd);
        logic [31:0] v;
        int off;
        off = int'(a % 4);
        case (sz)
            3'd0, 3'd4: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (sz == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                if (sz == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // ---------------- driver / bus responder ----------------
    // gd: cycles of req before gnt; rd: cycles from gnt to rvalid
    // (rd = 0 asserts rvalid only together with gnt).
    task automatic txn(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int gd, input int rd,
                       output int n_stall, output int n_req,
                       output int n_fault, output logic we_o,
                       output logic [3:0] be, output logic [31:0] wdat,
                       output logic [31:0] addr, output logic [31:0] dout,
                       output logic stable, output logic f_done,
                       output logic tmo);
        int c;
        int gcyc;
        logic done;
        n_stall = 0; n_req = 0; n_fault = 0; stable = 1'b1;
        f_done = 1'b0; dout = 32'd0; we_o = 1'b0; be = 4'd0;
        wdat = 32'd0; addr = 32'd0; gcyc = -1; done = 1'b0; c = 0;
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz;
        lsu_addr_i = a; lsu_data_i = wd; data_rdata_i = rdat;
        while (!done && c < 40) begin
            if (c > 0) @(negedge clk);
            data_gnt_i = data_req_o && (n_req == gd);
            if (rd == 0) data_rvalid_i = data_gnt_i;
            else data_rvalid_i = (gcyc >= 0) && (c == gcyc + rd);
            #1;
            if (data_req_o) begin
                if (n_req == 0) begin
                    be = data_be_o; wdat = data_wdata_o;
                    addr = data_addr_o; we_o = data_we_o;
                end else if (be !== data_be_o || addr !== data_addr_o ||
                             wdat !== data_wdata_o || we_o !== data_we_o) begin
                    stable = 1'b0;
                end
                if (data_gnt_i) gcyc = c;
                n_req++;
            end
            if (lsu_fault_o) n_fault++;
            if (lsu_stall_req_o) n_stall++;
            else begin
                dout = lsu_data_o; f_done = lsu_fault_o; done = 1'b1;
            end
            c++;
        end
        tmo = !done;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
            #1;
            if (lsu_fault_o) n_fault++;
            if (data_req_o) n_req++;
        end
    endtask

    int ns, nr, nf;
    logic wo, st, fd, to;
    logic [3:0] be;
    logic [31:0] wdat, addr, dout;

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
        lsu_addr_i = 32'd0; lsu_data_i = 32'd0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #1;
        n_total++;
        if ({data_req_o, data_we_o, lsu_fault_o, lsu_stall_req_o} !== 4'b0)
            $display("FAIL reset_ctl got %b want 0000",
                     {data_req_o, data_we_o, lsu_fault_o, lsu_stall_req_o});
        else n_pass++;
        n_total++;
        if (data_be_o !== 4'd0 || lsu_data_o !== 32'd0)
            $display("FAIL reset_data got be=%h d=%h want 0/0",
                     data_be_o, lsu_data_o);
        else n_pass++;
    endtask

    task automatic test_store_word;
        txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 0, 1,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (be !== 4'hF || wdat !== 32'hDEADBEEF || addr !== 32'h100 || wo !== 1'b1)
            $display("FAIL sw_bus got be=%h wd=%h a=%h we=%b want f/deadbeef/100/1",
                     be, wdat, addr, wo);
        else n_pass++;
        n_total++;
        if (ns !== 3 || nr !== 1 || nf !== 0 || to !== 1'b0)
            $display("FAIL sw_timing got stall=%0d req=%0d flt=%0d to=%b want 3/1/0/0",
                     ns, nr, nf, to);
        else n_pass++;
    endtask

    task automatic test_loads;
        logic [2:0]  szs [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd2};
        logic [31:0] as  [6] = '{32'h103, 32'h103, 32'h102, 32'h102,
                                 32'h104, 32'h108};
        logic [31:0] rds [6] = '{32'h80FF_FF00, 32'h80FF_FF00, 32'h8001_1234,
                                 32'h8001_1234, 32'h1234_5678, 32'hCAFE_F00D};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                 32'h0000_8001, 32'h1234_5678, 32'hCAFE_F00D};
        logic [3:0]  ebe [6] = '{4'h8, 4'h8, 4'hC, 4'hC, 4'hF, 4'hF};
        for (int i = 0; i < 6; i++) begin
            txn(1'b0, szs[i], as[i], 32'd0, rds[i], 0, 1,
                ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
            n_total++;
            if (dout !== exp[i] || be !== ebe[i] || nf !== 0 || ns !== 3)
                $display("FAIL load_%0d got d=%h be=%h f=%0d s=%0d want %h/%h/0/3",
                         i, dout, be, nf, ns, exp[i], ebe[i]);
            else n_pass++;
        end
        txn(1'b1, 3'd1, 32'h102, 32'h1234_ABCD, 32'd0, 0, 1,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (be !== 4'hC || wdat !== 32'hABCD_ABCD || addr !== 32'h100)
            $display("FAIL sh got be=%h wd=%h a=%h want c/abcdabcd/100",
                     be, wdat, addr);
        else n_pass++;
    endtask

    task automatic test_misaligned;
        txn(1'b0, 3'd2, 32'h101, 32'd0, 32'd0, 0, 1,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (nr !== 0 || nf !== 1 || ns !== 0)
            $display("FAIL lw_misalign got req=%0d flt=%0d stall=%0d want 0/1/0",
                     nr, nf, ns);
        else n_pass++;
        txn(1'b1, 3'd6, 32'h100, 32'd0, 32'd0, 0, 1,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (nr !== 0 || nf !== 1 || ns !== 0)
            $display("FAIL bad_size got req=%0d flt=%0d stall=%0d want 0/1/0",
                     nr, nf, ns);
        else n_pass++;
    endtask

    task automatic test_wait_states;
        txn(1'b0, 3'd2, 32'h0000_2040, 32'd0, 32'h5555_AAAA, 4, 2,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (st !== 1'b1 || nr !== 5 || addr !== 32'h2040)
            $display("FAIL wait_stable got st=%b req=%0d a=%h want 1/5/2040",
                     st, nr, addr);
        else n_pass++;
        n_total++;
        if (ns !== 8 || dout !== 32'h5555_AAAA || nf !== 0)
            $display("FAIL wait_done got s=%0d d=%h f=%0d want 8/5555aaaa/0",
                     ns, dout, nf);
        else n_pass++;
    endtask

    task automatic test_timeout;
        txn(1'b0, 3'd2, 32'h300, 32'd0, 32'h1111_2222, 99, 1,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (nr !== 8 || ns !== 9 || fd !== 1'b1 || nf !== 1 || dout !== 32'd0)
            $display("FAIL timeout_req got req=%0d s=%0d fd=%b f=%0d d=%h want 8/9/1/1/0",
                     nr, ns, fd, nf, dout);
        else n_pass++;
        // rvalid only alongside gnt is not a response
        txn(1'b0, 3'd2, 32'h304, 32'd0, 32'h3333_4444, 0, 0,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (nr !== 1 || ns !== 9 || fd !== 1'b1 || dout !== 32'd0)
            $display("FAIL same_cycle_rvalid got req=%0d s=%0d fd=%b d=%h want 1/9/1/0",
                     nr, ns, fd, dout);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2;
        lsu_addr_i = 32'h400; data_rdata_i = 32'h7777_8888;
        @(negedge clk);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0; rst_i = 1'b1; lsu_req_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0; data_rvalid_i = 1'b1;
        #1;
        n_total++;
        if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b0)
            $display("FAIL rst_mid got req=%b stall=%b want 0/0",
                     data_req_o, lsu_stall_req_o);
        else n_pass++;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        #1;
        n_total++;
        if (lsu_data_o !== 32'd0 || lsu_fault_o !== 1'b0 || lsu_stall_req_o !== 1'b0)
            $display("FAIL late_rvalid got d=%h f=%b s=%b want 0/0/0",
                     lsu_data_o, lsu_fault_o, lsu_stall_req_o);
        else n_pass++;
        txn(1'b0, 3'd4, 32'h401, 32'd0, 32'h0000_9A00, 1, 1,
            ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
        n_total++;
        if (dout !== 32'h0000_009A || ns !== 4)
            $display("FAIL after_rst got d=%h s=%0d want 9a/4", dout, ns);
        else n_pass++;
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  sz;
        logic [31:0] a, wd, rdat;
        int gd, rd;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1)); sz = 3'($urandom_range(0, 7));
            a = $urandom; wd = $urandom; rdat = $urandom;
            gd = $urandom_range(0, 3); rd = $urandom_range(1, 3);
            txn(we, sz, a, wd, rdat, gd, rd,
                ns, nr, nf, wo, be, wdat, addr, dout, st, fd, to);
            if (legal_m(sz, a)) begin
                n_total++;
                if (ns !== gd + rd + 2 || nr !== gd + 1 || nf !== 0 ||
                    st !== 1'b1 || to !== 1'b0)
                    $display("FAIL rnd_timing[%0d] got s=%0d r=%0d f=%0d st=%b want %0d/%0d/0/1",
                             i, ns, nr, nf, st, gd + rd + 2, gd + 1);
                else n_pass++;
                n_total++;
                if (be !== be_m(sz, a) || addr !== (a & 32'hFFFF_FFFC) || wo !== we)
                    $display("FAIL rnd_bus[%0d] got be=%h a=%h we=%b want %h/%h/%b",
                             i, be, addr, wo, be_m(sz, a), a & 32'hFFFF_FFFC, we);
                else n_pass++;
                n_total++;
                if (we ? (wdat !== wd_m(sz, wd)) : (dout !== ld_m(sz, a, rdat)))
                    $display("FAIL rnd_data[%0d] got %h want %h", i,
                             we ? wdat : dout,
                             we ? wd_m(sz, wd) : ld_m(sz, a, rdat));
                else n_pass++;
            end else begin
                n_total++;
                if (nr !== 0 || nf !== 1 || ns !== 0)
                    $display("FAIL rnd_illegal[%0d] got r=%0d f=%0d s=%0d want 0/1/0",
                             i, nr, nf, ns);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_loads;
        test_misaligned;
        test_wait_states;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
